// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, IR field positions and datapath widths.
package sisc_pkg;

  localparam int PC_W = 16;
  localparam int IR_W = 32;

  typedef enum logic [3:0] {
    NOOP   = 4'h0,
    LOD    = 4'h1,
    STR    = 4'h2,
    SWP    = 4'h3,
    BRA    = 4'h4,
    BRR    = 4'h5,
    BNE    = 4'h6,
    BNR    = 4'h7,
    ALU_OP = 4'h8,
    HLT    = 4'hF
  } opcode_e;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int MM_HI  = 27;
  localparam int MM_LO  = 24;
  localparam int RD_HI  = 23;
  localparam int RD_LO  = 20;
  localparam int RS_HI  = 19;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 12;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [3:0] AM_IMM = 4'd8;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control FSM commands, instruction memory port and decoded IR fields.
interface fetch_unit_if;
  import sisc_pkg::*;

  logic            pc_rst;
  logic            pc_write;
  logic            pc_sel;
  logic            br_sel;
  logic            ir_load;
  logic [IR_W-1:0] im_data;
  logic [PC_W-1:0] im_addr;
  logic [PC_W-1:0] pc_out;
  logic [PC_W-1:0] ir_pc;
  logic [3:0]      opcode;
  logic [3:0]      mm;
  logic [3:0]      rd;
  logic [3:0]      rs;
  logic [3:0]      rt;
  logic [15:0]     imm;
  logic [31:0]     instr_cnt;
  logic [31:0]     br_cnt;

  // Master is the control FSM / memory side; slave is the fetch unit itself.
  modport master (
    output pc_rst, pc_write, pc_sel, br_sel, ir_load, im_data,
    input  im_addr, pc_out, ir_pc, opcode, mm, rd, rs, rt, imm, instr_cnt, br_cnt
  );

  modport slave (
    input  pc_rst, pc_write, pc_sel, br_sel, ir_load, im_data,
    output im_addr, pc_out, ir_pc, opcode, mm, rd, rs, rt, imm, instr_cnt, br_cnt
  );

endinterface

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select: PC+1, absolute immediate, or PC-relative sign-extended offset.
module fetch_pc_next
  import sisc_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  input  logic            pc_sel,
  input  logic            br_sel,
  output logic [PC_W-1:0] pc_next
);

  logic [PC_W-1:0] imm_abs;
  logic [PC_W-1:0] imm_sext;

  assign imm_abs  = PC_W'(imm);
  assign imm_sext = PC_W'(signed'(imm));

  // All sums wrap modulo 2^PC_W; PC already points past the branch when this is used.
  always_comb begin
    pc_next = pc + PC_W'(1);
    if (pc_sel) begin
      if (br_sel) pc_next = imm_abs;
      else        pc_next = pc + imm_sext;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// SISC fetch stage: PC, IR and ir_pc registers with combinational IR field decode.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import sisc_pkg::*;
(
  input logic         clk,
  input logic         rst_f,
  fetch_unit_if.slave bus
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] ir_pc;
  logic [IR_W-1:0] ir;

  fetch_pc_next u_pc_next (
    .pc      (pc),
    .imm     (ir[IMM_HI:IMM_LO]),
    .pc_sel  (bus.pc_sel),
    .br_sel  (bus.br_sel),
    .pc_next (pc_next)
  );

  // pc_rst overrides any load/write in the same cycle; IR loads use the pre-update PC.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc    <= '0;
      ir    <= '0;
      ir_pc <= '0;
    end else if (bus.pc_rst) begin
      pc    <= '0;
      ir    <= '0;
      ir_pc <= '0;
    end else begin
      if (bus.ir_load) begin
        ir    <= bus.im_data;
        ir_pc <= pc;
      end
      if (bus.pc_write) pc <= pc_next;
    end
  end

  assign bus.im_addr = pc;
  assign bus.pc_out  = pc;
  assign bus.ir_pc   = ir_pc;
  assign bus.opcode  = ir[OPC_HI:OPC_LO];
  assign bus.mm      = ir[MM_HI:MM_LO];
  assign bus.rd      = ir[RD_HI:RD_LO];
  assign bus.rs      = ir[RS_HI:RS_LO];
  assign bus.rt      = ir[RT_HI:RT_LO];
  assign bus.imm     = ir[IMM_HI:IMM_LO];

`ifdef FETCH_PERF_EN
  logic [31:0] instr_cnt_q;
  logic [31:0] br_cnt_q;

  // Counters survive pc_rst and only count operations that pc_rst did not cancel.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      instr_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else if (!bus.pc_rst) begin
      if (bus.ir_load)                 instr_cnt_q <= instr_cnt_q + 32'd1;
      if (bus.pc_write && bus.pc_sel)  br_cnt_q    <= br_cnt_q + 32'd1;
    end
  end

  assign bus.instr_cnt = instr_cnt_q;
  assign bus.br_cnt    = br_cnt_q;
`else
  assign bus.instr_cnt = '0;
  assign bus.br_cnt    = '0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

SISC instruction-fetch stage: holds the program counter (PC) and instruction register (IR), drives the instruction-memory address, and decodes IR fields for the control FSM and datapath. It sits directly upstream of the control FSM, feeding it opcode/mm, and consumes that FSM's pc_rst, pc_write, pc_sel, br_sel and ir_load. All state changes are on clk rising edges, except the asynchronous reset.

## Interface
- PC_W, 16, PC and instruction-memory address width
- IR_W, 32, instruction width
- clk  in  1  system clock, rising edge
- rst_f  in  1  reset, asynchronous, active-low
- pc_rst  in  1  synchronous PC/IR clear (FSM start1)
- pc_write  in  1  PC update enable
- pc_sel  in  1  0: PC+1, 1: branch target
- br_sel  in  1  1: absolute target imm, 0: relative PC+sext(imm)
- ir_load  in  1  IR capture enable
- im_data  in  IR_W  instruction memory read data (combinational read at im_addr)
- im_addr  out  PC_W  equals PC
- pc_out  out  PC_W  current PC
- ir_pc  out  PC_W  address the current IR was fetched from
- opcode  out  4  IR[31:28]
- mm  out  4  IR[27:24]
- rd, rs, rt  out  4 each  IR[23:20], IR[19:16], IR[15:12]
- imm  out  16  IR[15:0]
- instr_cnt  out  32  fetched-instruction count (FETCH_PERF_EN)
- br_cnt  out  32  taken-branch count (FETCH_PERF_EN)

## Operation
- Registers: PC, IR, ir_pc, and optionally instr_cnt, br_cnt.
- Priority per edge: rst_f low > pc_rst > pc_write/ir_load.
- rst_f low (async): PC=0, IR=0 (NOOP), ir_pc=0, counters=0; held while low.
- pc_rst=1: PC=0, IR=0, ir_pc=0; counters unchanged; pc_write/ir_load ignored that cycle.
- ir_load=1: IR<=im_data, ir_pc<=PC (old PC, pre-update).
- pc_write=1, pc_sel=0: PC<=PC+1.
- pc_write=1, pc_sel=1, br_sel=1: PC<=imm of the *current* IR (not im_data).
- pc_write=1, pc_sel=1, br_sel=0: PC<=PC+sext16(imm). PC has already advanced past the branch during fetch, so the offset is relative to branch address+1.
- pc_write=0: PC holds. br_sel is don't-care when pc_sel=0.
- Arithmetic is modulo 2^PC_W: 0xFFFF+1 -> 0x0000; 0x0002+0xFFFD -> 0xFFFF.
- Simultaneous ir_load and pc_write (fetch state): IR captures the word at old PC; PC moves to old PC+1; ir_pc = old PC.
- Field outputs are combinational slices of IR. They change only on the edge after ir_load, pc_rst or rst_f.

## Timing
- im_addr is PC, registered, with zero combinational path from inputs.
- Fetch latency: the word at PC is visible on opcode/mm one edge after ir_load.
- A branch taken in decode changes PC on that edge. The next fetch state reads the target; no instruction is fetched from the wrong path.
- Reset values: im_addr=pc_out=ir_pc=0, opcode=mm=rd=rs=rt=0, imm=0, counters=0.
- rst_f deassertion mid-cycle: state stays 0 until the first rising edge after release.

## Configuration
- FETCH_PERF_EN defined: instr_cnt increments on every accepted ir_load. br_cnt increments on every accepted pc_write with pc_sel=1. Both wrap at 2^32. Both are cleared only by rst_f.
- Undefined: no counter flops; instr_cnt and br_cnt tied to 0. Ports remain so the interface is fixed.

## Structure
- Shared package sisc_pkg holds:
  - opcode constants: NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15;
  - IR field bit positions (OPC_HI/LO, MM_HI/LO, RD/RS/RT, IMM);
  - PC_W and IR_W defaults;
  - AM_IMM=8.
- Sub-module fetch_pc_next: a combinational next-PC mux/adder. Inputs: PC, imm, pc_sel, br_sel. Output: next PC.

## Test plan
- rst_f low mid-run with PC=0x0012 -> pc_out=0, opcode=0 immediately, without waiting for a clock edge. After release plus 3 edges with pc_write=ir_load=0, all outputs stay 0.
- Fetch with im_data=0x41230005 at PC=0x0007, pc_write=ir_load=1 -> PC=0x0008, opcode=4, mm=1, imm=0x0005, ir_pc=0x0007.
- Absolute branch: IR imm=0x0030, pc_write=pc_sel=br_sel=1 -> PC=0x0030.
- Relative branch: PC=0x0008, imm=0xFFFC, br_sel=0 -> PC=0x0004. Wrap case: PC=0xFFFF, imm=0x0002 -> PC=0x0001.
- pc_rst together with pc_write=ir_load=1 -> PC=0, IR=0. With FETCH_PERF_EN, instr_cnt unchanged.
- With FETCH_PERF_EN: 5 fetches + 2 taken branches -> instr_cnt=5, br_cnt=2. Without the macro, both read 0.
